// File: rtl/hdmi_mode_ctrl.sv
// Video-mode sequencer: applies requested timing modes at a frame boundary with the generator held in reset.
// Optional frame_count output is enabled by defining HDMI_MODE_CTRL_FRAMECNT_EN.
module hdmi_mode_ctrl #(
    parameter int HOLD_CYCLES    = 16,
    parameter int SETTLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int DEFAULT_MODE   = 0
) (
    input  logic        pix_clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  req_mode,
    input  logic        vs_in,
    output logic        ack,
    output logic        err,
    output logic        busy,
    output logic        mute,
    output logic        gen_rst_n,
    output logic [1:0]  cur_mode,
    output logic [11:0] h_total,
    output logic [11:0] h_sync,
    output logic [11:0] h_bporch,
    output logic [11:0] h_res,
    output logic [11:0] v_total,
    output logic [11:0] v_sync,
    output logic [11:0] v_bporch,
    output logic [11:0] v_res,
    output logic        hs_pol,
    output logic        vs_pol
`ifdef HDMI_MODE_CTRL_FRAMECNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int FRM_W  = $clog2(SETTLE_FRAMES) + 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(SETTLE_FRAMES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]        DEF_MODE  = 2'(DEFAULT_MODE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VBLANK,
        S_APPLY,
        S_SETTLE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_bporch;
        logic [11:0] h_res;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_bporch;
        logic [11:0] v_res;
        logic        hs_pol;
        logic        vs_pol;
    } timing_t;

    // Mode 3 never reaches this table through a request; it falls back to mode 0 values.
    function automatic timing_t mode_timing(input logic [1:0] m);
        timing_t t;
        case (m)
            2'd1:    t = '{12'd1056, 12'd128, 12'd88,  12'd800,  12'd628, 12'd4, 12'd23, 12'd600, 1'b1, 1'b1};
            2'd2:    t = '{12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720, 1'b1, 1'b1};
            default: t = '{12'd800,  12'd96,  12'd48,  12'd640,  12'd525, 12'd2, 12'd33, 12'd480, 1'b0, 1'b0};
        endcase
        return t;
    endfunction

    state_t              state, state_nxt;
    logic [1:0]          pend, pend_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [FRM_W-1:0]    frm_cnt, frm_nxt;
    logic [TO_W-1:0]     to_cnt, to_nxt;
    logic                silent, silent_nxt;
    logic                vs_q;
    logic                vs_edge;
    logic                timed_out;
    timing_t             tim, tim_nxt;
    logic                ack_nxt, err_nxt, busy_nxt, mute_nxt, gen_rst_n_nxt;
    logic [1:0]          cur_mode_nxt;

    assign h_total  = tim.h_total;
    assign h_sync   = tim.h_sync;
    assign h_bporch = tim.h_bporch;
    assign h_res    = tim.h_res;
    assign v_total  = tim.v_total;
    assign v_sync   = tim.v_sync;
    assign v_bporch = tim.v_bporch;
    assign v_res    = tim.v_res;
    assign hs_pol   = tim.hs_pol;
    assign vs_pol   = tim.vs_pol;

    assign vs_edge   = (vs_q != tim.vs_pol) && (vs_in == tim.vs_pol);
    assign timed_out = (to_cnt == TO_LAST);

    // silent marks a sequence started by reset, whose completion must not be acknowledged.
    always_comb begin
        state_nxt     = state;
        pend_nxt      = pend;
        hold_nxt      = hold_cnt;
        frm_nxt       = frm_cnt;
        to_nxt        = to_cnt;
        silent_nxt    = silent;
        tim_nxt       = tim;
        cur_mode_nxt  = cur_mode;
        ack_nxt       = 1'b0;
        err_nxt       = 1'b0;
        mute_nxt      = mute;
        gen_rst_n_nxt = gen_rst_n;

        case (state)
            S_IDLE: begin
                mute_nxt      = 1'b0;
                gen_rst_n_nxt = 1'b1;
                if (req) begin
                    pend_nxt = req_mode;
                    if (req_mode == 2'd3) begin
                        ack_nxt = 1'b1;
                        err_nxt = 1'b1;
                    end else if (req_mode == cur_mode) begin
                        ack_nxt = 1'b1;
                    end else begin
                        state_nxt = S_WAIT_VBLANK;
                        to_nxt    = '0;
                    end
                end
            end

            S_WAIT_VBLANK: begin
                mute_nxt      = 1'b0;
                gen_rst_n_nxt = 1'b1;
                if (vs_edge || timed_out) begin
                    state_nxt     = S_APPLY;
                    hold_nxt      = '0;
                    to_nxt        = '0;
                    mute_nxt      = 1'b1;
                    gen_rst_n_nxt = 1'b0;
                    cur_mode_nxt  = pend;
                    tim_nxt       = mode_timing(pend);
                end else begin
                    to_nxt = to_cnt + 1'b1;
                end
            end

            S_APPLY: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt     = S_SETTLE;
                    gen_rst_n_nxt = 1'b1;
                    to_nxt        = '0;
                    frm_nxt       = '0;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end

            // A frame that never shows a vsync still counts once its timeout expires.
            S_SETTLE: begin
                if (vs_edge || timed_out) begin
                    to_nxt = '0;
                    if (frm_cnt == FRM_LAST) begin
                        state_nxt  = S_DONE;
                        mute_nxt   = 1'b0;
                        ack_nxt    = !silent;
                        silent_nxt = 1'b0;
                    end else begin
                        frm_nxt = frm_cnt + 1'b1;
                    end
                end else begin
                    to_nxt = to_cnt + 1'b1;
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
                mute_nxt  = 1'b0;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // Reset lands directly in the APPLY entry cycle so the power-on mode goes through the same sequence.
    always_ff @(posedge pix_clk) begin
        vs_q <= vs_in;
        if (rst) begin
            state     <= S_APPLY;
            pend      <= DEF_MODE;
            hold_cnt  <= '0;
            frm_cnt   <= '0;
            to_cnt    <= '0;
            silent    <= 1'b1;
            tim       <= mode_timing(DEF_MODE);
            cur_mode  <= DEF_MODE;
            ack       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b1;
            mute      <= 1'b1;
            gen_rst_n <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            hold_cnt  <= hold_nxt;
            frm_cnt   <= frm_nxt;
            to_cnt    <= to_nxt;
            silent    <= silent_nxt;
            tim       <= tim_nxt;
            cur_mode  <= cur_mode_nxt;
            ack       <= ack_nxt;
            err       <= err_nxt;
            busy      <= busy_nxt;
            mute      <= mute_nxt;
            gen_rst_n <= gen_rst_n_nxt;
        end
    end

`ifdef HDMI_MODE_CTRL_FRAMECNT_EN
    // Counts frames only while the generator runs undisturbed; restarts with every mode application.
    always_ff @(posedge pix_clk) begin
        if (rst || (state_nxt == S_APPLY && state != S_APPLY)) begin
            frame_count <= '0;
        end else if (vs_edge && (state == S_IDLE || state == S_WAIT_VBLANK)) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hdmi_mode_ctrl.sv
// Directed testbench for hdmi_mode_ctrl with a scaled-down vsync generator (60-cycle frames).
module tb_hdmi_mode_ctrl;

    localparam int HOLD    = 16;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 200;
    localparam int PERIOD  = 60;

    localparam logic [97:0] MODE0 = {12'd800,  12'd96,  12'd48,  12'd640,  12'd525, 12'd2, 12'd33, 12'd480, 1'b0, 1'b0};
    localparam logic [97:0] MODE1 = {12'd1056, 12'd128, 12'd88,  12'd800,  12'd628, 12'd4, 12'd23, 12'd600, 1'b1, 1'b1};
    localparam logic [97:0] MODE2 = {12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720, 1'b1, 1'b1};

    logic        pix_clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  req_mode = 2'd0;
    logic        vs_in = 1'b1;
    logic        ack, err, busy, mute, gen_rst_n;
    logic [1:0]  cur_mode;
    logic [11:0] h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res;
    logic        hs_pol, vs_pol;
    logic [97:0] params;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int gcnt = 0;
    int edges = 0;
    int edge_cyc = 0;
    logic pulse = 1'b0;
    logic vs_hold = 1'b0;

    assign params = {h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res, hs_pol, vs_pol};

    hdmi_mode_ctrl #(
        .HOLD_CYCLES(HOLD), .SETTLE_FRAMES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT), .DEFAULT_MODE(0)
    ) dut (
        .pix_clk(pix_clk), .rst(rst), .req(req), .req_mode(req_mode), .vs_in(vs_in),
        .ack(ack), .err(err), .busy(busy), .mute(mute), .gen_rst_n(gen_rst_n), .cur_mode(cur_mode),
        .h_total(h_total), .h_sync(h_sync), .h_bporch(h_bporch), .h_res(h_res),
        .v_total(v_total), .v_sync(v_sync), .v_bporch(v_bporch), .v_res(v_res),
        .hs_pol(hs_pol), .vs_pol(vs_pol)
    );

    always #5 pix_clk = ~pix_clk;

    initial begin
        forever begin
            @(posedge pix_clk);
            cyc++;
        end
    end

    // Timing-generator model: restarts while held in reset, emits vsync at the polarity it is told to use.
    initial begin
        logic p;
        forever begin
            @(posedge pix_clk);
            #1;
            if (gen_rst_n !== 1'b1) begin
                gcnt  = 0;
                edges = 0;
            end else begin
                gcnt = (gcnt == PERIOD - 1) ? 0 : gcnt + 1;
            end
            p = !vs_hold && (gcnt >= 50) && (gcnt < 54);
            if (p && !pulse) begin
                edges++;
                edge_cyc = cyc;
            end
            pulse = p;
            vs_in = vs_pol ? pulse : ~pulse;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic issue_req(input logic [1:0] m);
        @(negedge pix_clk);
        req = 1'b1;
        req_mode = m;
        @(negedge pix_clk);
        req = 1'b0;
    endtask

    task automatic test_reset();
        int lows, n, acks;
        rst = 1'b1;
        @(negedge pix_clk);
        tests_run++;
        if ({busy, mute, gen_rst_n, ack, err} !== 5'b11000) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs got=%b want=11000", {busy, mute, gen_rst_n, ack, err});
        end
        tests_run++;
        if (params !== MODE0 || cur_mode !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_params got h_total=%0d mode=%0d want 800/0", h_total, cur_mode);
        end
        @(negedge pix_clk);
        @(negedge pix_clk);
        rst = 1'b0;
        lows = 0; n = 0; acks = 0;
        while (gen_rst_n === 1'b0 && n < 100) begin
            lows++; n++;
            if (ack !== 1'b0) acks++;
            @(negedge pix_clk);
        end
        tests_run++;
        if (lows != HOLD) begin
            tests_failed++;
            $display("[TB] FAIL reset_hold got=%0d want=%0d", lows, HOLD);
        end
        n = 0;
        while (mute !== 1'b0 && n < 1000) begin
            if (ack !== 1'b0) acks++;
            n++;
            @(negedge pix_clk);
        end
        tests_run++;
        if (mute !== 1'b0 || edges != SETTLE) begin
            tests_failed++;
            $display("[TB] FAIL reset_unmute got mute=%b edges=%0d want 0/%0d", mute, edges, SETTLE);
        end
        if (ack !== 1'b0) acks++;
        tests_run++;
        if (acks != 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_ack got=%0d want=0", acks);
        end
        @(negedge pix_clk);
        tests_run++;
        if (busy !== 1'b0 || ack !== 1'b0 || cur_mode !== 2'd0 || h_total !== 12'd800) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle got busy=%b ack=%b mode=%0d h_total=%0d", busy, ack, cur_mode, h_total);
        end
    endtask

    task automatic test_mode_change();
        int n, held_bad, busy_bad, lows, acks;
        n = 0;
        while (gcnt != 10 && n < 200) begin
            @(negedge pix_clk);
            n++;
        end
        issue_req(2'd2);
        held_bad = 0; busy_bad = 0; n = 0;
        while (gen_rst_n === 1'b1 && n < 300) begin
            if (busy !== 1'b1) busy_bad++;
            if (params !== MODE0 || cur_mode !== 2'd0) held_bad++;
            n++;
            @(negedge pix_clk);
        end
        tests_run++;
        if (held_bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL params_held got=%0d early changes want=0", held_bad);
        end
        tests_run++;
        if (gen_rst_n !== 1'b0 || cyc - edge_cyc != 1) begin
            tests_failed++;
            $display("[TB] FAIL apply_on_edge got gen_rst_n=%b delay=%0d want 0/1", gen_rst_n, cyc - edge_cyc);
        end
        tests_run++;
        if (params !== MODE2 || cur_mode !== 2'd2 || mute !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL apply_params got h_total=%0d vs_pol=%b mode=%0d mute=%b want 1650/1/2/1", h_total, vs_pol, cur_mode, mute);
        end
        lows = 0; n = 0;
        while (gen_rst_n === 1'b0 && n < 100) begin
            if (busy !== 1'b1) busy_bad++;
            lows++; n++;
            @(negedge pix_clk);
        end
        tests_run++;
        if (lows != HOLD) begin
            tests_failed++;
            $display("[TB] FAIL change_hold got=%0d want=%0d", lows, HOLD);
        end
        req = 1'b1;
        req_mode = 2'd1;
        @(negedge pix_clk);
        req = 1'b0;
        n = 0;
        while (ack !== 1'b1 && n < 500) begin
            if (busy !== 1'b1) busy_bad++;
            n++;
            @(negedge pix_clk);
        end
        tests_run++;
        if (ack !== 1'b1 || edges != SETTLE || mute !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL change_ack got ack=%b edges=%0d mute=%b busy=%b err=%b want 1/%0d/0/1/0", ack, edges, mute, busy, err, SETTLE);
        end
        tests_run++;
        if (busy_bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL change_busy got=%0d low cycles want=0", busy_bad);
        end
        acks = 0; busy_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge pix_clk);
            if (ack !== 1'b0) acks++;
            if (busy !== 1'b0) busy_bad++;
        end
        tests_run++;
        if (acks != 0 || busy_bad != 0 || cur_mode !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL busy_req_ignored got acks=%0d busy=%0d mode=%0d want 0/0/2", acks, busy_bad, cur_mode);
        end
    endtask

    task automatic test_same_mode();
        int bad;
        issue_req(2'd2);
        tests_run++;
        if (ack !== 1'b1 || err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL same_mode_ack got ack=%b err=%b want 1/0", ack, err);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge pix_clk);
            if (ack !== 1'b0 || gen_rst_n !== 1'b1 || mute !== 1'b0 || busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0 || params !== MODE2) begin
            tests_failed++;
            $display("[TB] FAIL same_mode_quiet got=%0d bad cycles want=0", bad);
        end
    endtask

    task automatic test_invalid();
        int bad;
        issue_req(2'd3);
        tests_run++;
        if (ack !== 1'b1 || err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL invalid_ack_err got ack=%b err=%b want 1/1", ack, err);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge pix_clk);
            if (ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || mute !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0 || params !== MODE2 || cur_mode !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL invalid_unchanged got bad=%0d mode=%0d h_total=%0d want 0/2/1650", bad, cur_mode, h_total);
        end
    endtask

    task automatic test_timeout();
        int n, t_busy, t_apply;
        vs_hold = 1'b1;
        repeat (3) @(negedge pix_clk);
        issue_req(2'd1);
        t_busy = cyc;
        n = 0;
        while (gen_rst_n === 1'b1 && n < 1000) begin
            n++;
            @(negedge pix_clk);
        end
        t_apply = cyc;
        tests_run++;
        if (gen_rst_n !== 1'b0 || t_apply - t_busy != TIMEOUT) begin
            tests_failed++;
            $display("[TB] FAIL timeout_apply got=%0d cycles want=%0d", t_apply - t_busy, TIMEOUT);
        end
        tests_run++;
        if (params !== MODE1 || cur_mode !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_params got h_total=%0d mode=%0d want 1056/1", h_total, cur_mode);
        end
        n = 0;
        while (ack !== 1'b1 && n < 2000) begin
            n++;
            @(negedge pix_clk);
        end
        // Counted from the first APPLY cycle through the DONE cycle that carries ack.
        tests_run++;
        if (ack !== 1'b1 || cyc - t_apply != HOLD + 2 * TIMEOUT) begin
            tests_failed++;
            $display("[TB] FAIL timeout_ack got ack=%b after %0d want 1 after %0d", ack, cyc - t_apply, HOLD + 2 * TIMEOUT);
        end
        vs_hold = 1'b0;
    endtask

    task automatic test_mid_reset();
        int n, acks;
        issue_req(2'd0);
        n = 0;
        while (ack !== 1'b1 && n < 1000) begin
            n++;
            @(negedge pix_clk);
        end
        tests_run++;
        if (ack !== 1'b1 || cur_mode !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL back_to_mode0 got ack=%b mode=%0d want 1/0", ack, cur_mode);
        end
        @(negedge pix_clk);
        issue_req(2'd1);
        n = 0;
        while (gen_rst_n === 1'b1 && n < 500) begin n++; @(negedge pix_clk); end
        n = 0;
        while (gen_rst_n === 1'b0 && n < 100) begin n++; @(negedge pix_clk); end
        repeat (5) @(negedge pix_clk);
        tests_run++;
        if (mute !== 1'b1 || gen_rst_n !== 1'b1 || cur_mode !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL in_settle got mute=%b gen_rst_n=%b mode=%0d want 1/1/1", mute, gen_rst_n, cur_mode);
        end
        rst = 1'b1;
        req = 1'b1;
        req_mode = 2'd2;
        @(negedge pix_clk);
        rst = 1'b0;
        req = 1'b0;
        tests_run++;
        if (params !== MODE0 || cur_mode !== 2'd0 || {gen_rst_n, mute, busy, ack, err} !== 5'b01100) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset got h_total=%0d mode=%0d flags=%b want 800/0/01100", h_total, cur_mode, {gen_rst_n, mute, busy, ack, err});
        end
        acks = 0; n = 0;
        while (mute !== 1'b0 && n < 1000) begin
            if (ack !== 1'b0) acks++;
            n++;
            @(negedge pix_clk);
        end
        if (ack !== 1'b0) acks++;
        repeat (3) begin
            @(negedge pix_clk);
            if (ack !== 1'b0) acks++;
        end
        tests_run++;
        if (mute !== 1'b0 || acks != 0 || cur_mode !== 2'd0 || params !== MODE0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_no_ack got mute=%b acks=%0d mode=%0d busy=%b want 0/0/0/0", mute, acks, cur_mode, busy);
        end
    endtask

    initial begin
        test_reset();
        test_mode_change();
        test_same_mode();
        test_invalid();
        test_timeout();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hdmi_mode_ctrl.md
Name: hdmi_mode_ctrl

Overview:
Video-mode sequencer for the HDMI output path. Runs in the pixel clock domain and drives the timing-parameter inputs, polarity inputs and active-low reset of the test-pattern/timing generator. Accepts mode-change requests over a req/ack handshake and applies them only at a frame boundary, with the output muted and the generator held in reset. Output is un-muted after a programmable number of clean frames.

Parameters:
HOLD_CYCLES, 16, cycles gen_rst_n is held low during APPLY (≥1)
SETTLE_FRAMES, 2, vsync leading edges counted in SETTLE before un-mute (≥1)
TIMEOUT_CYCLES, 2000000, max cycles waited for any single vsync edge before proceeding anyway
DEFAULT_MODE, 0, mode applied after reset (0..2)

Ports:
pix_clk  in  1  pixel clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  1  mode-change request (level)
req_mode  in  2  requested mode: 0=640x480@60, 1=800x600@60, 2=1280x720@60, 3=invalid
vs_in  in  1  vsync from timing generator (polarity per vs_pol)
ack  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse coincident with ack for an invalid mode
busy  out  1  high whenever state ≠ IDLE
mute  out  1  downstream forces DE=0 and RGB=0 while high
gen_rst_n  out  1  active-low reset to the timing generator
cur_mode  out  2  mode currently applied
h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res  out  12 each  timing parameters
hs_pol, vs_pol  out  1 each  sync polarity (1 = positive)

Behaviour:
- Mode table (h_total/h_sync/h_bporch/h_res/v_total/v_sync/v_bporch/v_res/hs_pol/vs_pol):
  - mode 0: 800/96/48/640/525/2/33/480/0/0
  - mode 1: 1056/128/88/800/628/4/23/600/1/1
  - mode 2: 1650/40/220/1280/750/5/20/720/1/1
- All outputs registered.
- vsync edge: vs_in registered once into vs_q. Edge = (vs_q ≠ vs_pol) and (vs_in == vs_pol), using the vs_pol in effect at that cycle.
- States:
  - IDLE: busy=0, mute=0, gen_rst_n=1.
    - On req=1, capture req_mode into pend.
    - pend=3 → ack=1, err=1 next cycle; stay in IDLE; params unchanged.
    - pend=cur_mode → ack=1 next cycle; stay in IDLE; no reset.
    - Otherwise → WAIT_VBLANK.
    - req is sampled only in IDLE. A request made while busy is ignored. A req held high after ack re-issues the request (same-mode case acks again).
  - WAIT_VBLANK: mute=0, timeout counter running.
    - On vsync edge or counter = TIMEOUT_CYCLES-1 → APPLY.
  - APPLY (entry cycle):
    - mute=1, gen_rst_n=0; params, polarities and cur_mode switch to pend.
    - Hold for HOLD_CYCLES cycles, then gen_rst_n=1 → SETTLE.
  - SETTLE: mute=1.
    - Count vsync edges. The timeout counter restarts per frame; a timeout counts as an edge.
    - After SETTLE_FRAMES edges → DONE.
  - DONE (one cycle): mute=0, ack=1, busy=1 → IDLE.
- Latency:
  - Same-mode or invalid request: ack one cycle after acceptance.
  - Valid change: ack = wait for vsync + HOLD_CYCLES + SETTLE_FRAMES frames + 1 cycle.
- Reset (any time, including mid-sequence):
  - Next state APPLY with pend=DEFAULT_MODE; params = DEFAULT_MODE values.
  - mute=1, gen_rst_n=0, busy=1, ack=0, err=0; all counters cleared.
  - The power-on sequence completes through SETTLE/DONE; DONE does not pulse ack after reset.
- Simultaneous rst and req: rst wins and req is dropped.
- Counter widths: sized by $clog2 of the respective parameter + 1; no wrap is possible before the terminal compare.

Optional Feature:
HDMI_MODE_CTRL_FRAMECNT_EN:
- Defined: adds output frame_count[15:0], incremented on each vsync edge while in IDLE or WAIT_VBLANK. Cleared to 0 on rst and on entering APPLY. Wraps 0xFFFF→0.
- Undefined: port absent and no counter logic.

Test Plan:
- Reset: hold rst for 3 cycles, then release, with vs_in toggling in mode 0 timing. Expect gen_rst_n=0 for exactly 16 cycles; mute falls after the 2nd vsync edge; no ack; h_total=800, cur_mode=0.
- Mode change: in IDLE, req=1 with req_mode=2. Expect params unchanged until the next vsync edge; on that edge h_total=1650, vs_pol=1, gen_rst_n low for 16 cycles. Expect one ack pulse after 2 positive-polarity vsync edges; busy high throughout.
- Same mode: req with req_mode=cur_mode=2. Expect ack one cycle later, err=0, and gen_rst_n and mute never asserted.
- Invalid mode: req with req_mode=3. Expect ack=1 and err=1 in the same cycle; cur_mode and all params unchanged.
- Timeout: hold vs_in constant after a request for mode 1. Expect APPLY entered exactly TIMEOUT_CYCLES cycles later, and ack after a further 2×TIMEOUT_CYCLES + 16 + 1 cycles.
- Mid-sequence reset: assert rst during SETTLE of a 0→1 change. Expect the next cycle to show params in mode 0, gen_rst_n=0, mute=1, and no ack for the aborted request.
